// File: rtl/display7_pkg.sv
// Shared 7-segment definitions: hex patterns (bit6=a .. bit0=g, active high),
// width constants and the classification of an accepted bus sample.
package display7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_CODE,
        CLS_ERR
    } cls_e;

    // Forward encoding, for the encoder and for loopback stimulus.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] v);
        case (v)
            4'h0:    return SEG_HEX_0;
            4'h1:    return SEG_HEX_1;
            4'h2:    return SEG_HEX_2;
            4'h3:    return SEG_HEX_3;
            4'h4:    return SEG_HEX_4;
            4'h5:    return SEG_HEX_5;
            4'h6:    return SEG_HEX_6;
            4'h7:    return SEG_HEX_7;
            4'h8:    return SEG_HEX_8;
            4'h9:    return SEG_HEX_9;
            4'hA:    return SEG_HEX_A;
            4'hB:    return SEG_HEX_B;
            4'hC:    return SEG_HEX_C;
            4'hD:    return SEG_HEX_D;
            4'hE:    return SEG_HEX_E;
            default: return SEG_HEX_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_para_hex.sv
// Combinational reverse lookup of a 7-segment pattern to {valid, nibble}.
module seg7_para_hex
    import display7_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic             o_valid,
    output logic [NIB_W-1:0] o_nib
);

    always_comb begin
        o_valid = 1'b1;
        o_nib   = '0;
        case (i_seg)
            SEG_HEX_0: o_nib = 4'h0;
            SEG_HEX_1: o_nib = 4'h1;
            SEG_HEX_2: o_nib = 4'h2;
            SEG_HEX_3: o_nib = 4'h3;
            SEG_HEX_4: o_nib = 4'h4;
            SEG_HEX_5: o_nib = 4'h5;
            SEG_HEX_6: o_nib = 4'h6;
            SEG_HEX_7: o_nib = 4'h7;
            SEG_HEX_8: o_nib = 4'h8;
            SEG_HEX_9: o_nib = 4'h9;
            SEG_HEX_A: o_nib = 4'hA;
            SEG_HEX_B: o_nib = 4'hB;
            SEG_HEX_C: o_nib = 4'hC;
            SEG_HEX_D: o_nib = 4'hD;
            SEG_HEX_E: o_nib = 4'hE;
            SEG_HEX_F: o_nib = 4'hF;
            default:   o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/decodificador_7seg.sv
// Recovers the hex word shown on a multiplexed 7-segment bus: debounce each
// digit for STABLE samples, classify it, and publish once all digits are seen.
module decodificador_7seg
    import display7_pkg::*;
#(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SEG_W-1:0]       seg,
    input  logic [NDIG-1:0]        dig_sel,
    output logic [NIB_W-1:0]       code_out,
    output logic [IDX_W-1:0]       code_idx,
    output logic                   code_ok,
    output logic [NIB_W*NDIG-1:0]  valor,
    output logic                   frame_valid,
    output logic                   err
);

    localparam logic [CNT_W-1:0] L_STABLE = CNT_W'(STABLE);
    localparam logic [CNT_W-1:0] L_PRE    = CNT_W'(STABLE - 1);

    logic [SEG_W-1:0]       r_seg;
    logic [NDIG-1:0]        r_sel;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_acc;
    logic [NIB_W*NDIG-1:0]  r_slots;
    logic [NDIG-1:0]        r_mask;

    logic                   w_same;
    logic                   w_hex_ok;
    logic [NIB_W-1:0]       w_nib;
    logic                   w_onehot;
    logic [IDX_W-1:0]       w_idx;
    cls_e                   w_cls;
    logic                   w_frame_done;
    logic [NDIG-1:0]        w_mask_nxt;

    assign w_same = ({seg, dig_sel} == {r_seg, r_sel});

    // r_acc marks the sample whose count has just reached STABLE; it is
    // classified one edge later so outputs land at k+STABLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '0;
            r_sel <= '0;
            r_cnt <= '0;
            r_acc <= 1'b0;
        end else begin
            r_seg <= seg;
            r_sel <= dig_sel;
            r_acc <= w_same && (r_cnt == L_PRE);
            if (!w_same) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt < L_STABLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    seg7_para_hex u_lookup (
        .i_seg   (r_seg),
        .o_valid (w_hex_ok),
        .o_nib   (w_nib)
    );

    assign w_onehot = ((r_sel & (r_sel - NDIG'(1))) == '0);

    always_comb begin
        w_idx = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (r_sel[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_cls = CLS_NONE;
        if (r_acc) begin
            if ((r_sel == '0) || (r_seg == SEG_BLANK)) begin
                w_cls = CLS_NONE;
            end else if (!w_onehot || !w_hex_ok) begin
                w_cls = CLS_ERR;
            end else begin
                w_cls = CLS_CODE;
            end
        end
    end

    // Clearing on completion comes first so a capture in the same cycle
    // already belongs to the next frame.
    assign w_frame_done = (r_mask == '1);

    always_comb begin
        w_mask_nxt = w_frame_done ? '0 : r_mask;
        if (w_cls == CLS_CODE) begin
            w_mask_nxt = w_mask_nxt | r_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slots <= '0;
            r_mask  <= '0;
        end else begin
            r_mask <= w_mask_nxt;
            if (w_cls == CLS_CODE) begin
                for (int unsigned i = 0; i < NDIG; i++) begin
                    if (r_sel[i]) begin
                        r_slots[NIB_W*i +: NIB_W] <= w_nib;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_out    <= '0;
            code_idx    <= '0;
            code_ok     <= 1'b0;
            err         <= 1'b0;
            valor       <= '0;
            frame_valid <= 1'b0;
        end else begin
            code_ok     <= (w_cls == CLS_CODE);
            err         <= (w_cls == CLS_ERR);
            frame_valid <= w_frame_done;
            if (w_cls == CLS_CODE) begin
                code_out <= w_nib;
                code_idx <= w_idx;
            end
            if (w_frame_done) begin
                valor <= r_slots;
            end
        end
    end

endmodule
